fb_reader: RTL and testbench

// - Framebuffer readback engine: the reader counterpart of the port-B pixel writer.
// - On start, scans the 1-bpp framebuffer over RAM port B in raster order and packs

---
 rtl/fb_reader.sv | 199 +++++++++++++++++++
 tb/tb_fb_reader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_reader.sv
// Purpose: scans the 1-bpp framebuffer over RAM port B in raster order and packs pixels MSB-first into bytes.
// Latency: at least 2 cycles per pixel (REQ + WAIT); a packed byte reaches byte_data one cycle after its FIFO write.
// Backpressure: a full FIFO stalls the scan in PUSH with no RAM request; abort flushes everything.
// Optional: define FB_READER_CRC_EN to add a CRC-8 (poly 0x07) output over every pushed byte.
module fb_reader #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic [8:0]                    x_b,
    output logic [7:0]                    y_b,
    output logic                          read_b,
    input  logic                          out_b,
    input  logic                          rdy_b,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef FB_READER_CRC_EN
    ,
    output logic [7:0]                    crc
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [8:0] X_LAST = 9'(FB_W - 1);
    localparam logic [7:0] Y_LAST = 8'(FB_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [8:0]      x_q;
    logic [7:0]      y_q;
    logic [7:0]      pack_q;
    logic [2:0]      bit_q;
    logic            stale_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   cnt_q;

    logic            start_ok, take, advance, push, pop;
    logic            last_px, fifo_full;

    assign last_px    = (x_q == X_LAST) && (y_q == Y_LAST);
    assign fifo_full  = (cnt_q == LW'(FIFO_DEPTH));
    assign byte_valid = (cnt_q != '0);
    assign pop        = byte_valid && byte_ready;
    assign byte_data  = byte_valid ? mem[rd_ptr] : 8'h00;
    assign level      = cnt_q;
    assign x_b        = x_q;
    assign y_b        = y_q;
    assign busy       = (state_q != S_IDLE) && !done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and strobes; abort overrides everything, including a simultaneous start.
    always_comb begin
        state_d  = state_q;
        read_b   = 1'b0;
        start_ok = 1'b0;
        take     = 1'b0;
        advance  = 1'b0;
        push     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                start_ok = 1'b1;
                state_d  = S_REQ;
            end
            // Hold off while a response to a request issued before an abort is still due.
            S_REQ: if (!stale_q) begin
                read_b  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (rdy_b) begin
                take = 1'b1;
                if (bit_q == 3'd7) begin
                    state_d = S_PUSH;
                end else begin
                    advance = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_PUSH: if (!fifo_full) begin
                push = 1'b1;
                if (last_px) begin
                    state_d = S_DRAIN;
                end else begin
                    advance = 1'b1;
                    state_d = S_REQ;
                end
            end
            // No writes happen here, so the last pop from a single entry is the final byte.
            S_DRAIN: if (pop && cnt_q == LW'(1)) begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            read_b   = 1'b0;
            start_ok = 1'b0;
            take     = 1'b0;
            advance  = 1'b0;
            push     = 1'b0;
            done     = 1'b0;
        end
    end

    // Raster address, pixel packing and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            pack_q <= '0;
            bit_q  <= '0;
        end else if (abort || start_ok) begin
            x_q    <= '0;
            y_q    <= '0;
            pack_q <= '0;
            bit_q  <= '0;
        end else begin
            if (take) begin
                pack_q <= {pack_q[6:0], out_b};
                bit_q  <= bit_q + 3'd1;
            end
            if (advance) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + 8'd1;
                end else begin
                    x_q <= x_q + 9'd1;
                end
            end
        end
    end

    // Remember a RAM read left in flight by an abort so its late rdy_b is swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    stale_q <= 1'b0;
        else if (abort && state_q == S_WAIT && !rdy_b) stale_q <= 1'b1;
        else if (rdy_b)                                stale_q <= 1'b0;
    end

    // FIFO storage; contents need no reset because byte_data is gated by byte_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pack_q;
    end

    // FIFO pointers and occupancy; abort flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef FB_READER_CRC_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Running CRC over pushed bytes; holds after the last push until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 crc <= 8'h00;
        else if (abort || start_ok) crc <= 8'h00;
        else if (push)              crc <= crc8_step(crc, pack_q);
    end
`endif

endmodule

// File: tb/tb_fb_reader.sv
// Purpose: randomized self-checking bench for fb_reader on a reduced 32x6 frame.
// Latency: RAM responder answers 1..5 cycles after read_b; consumer accepts per selectable mode.
// Backpressure: consumer can hold byte_ready low, always high, or randomize it.
module tb_fb_reader;
    localparam int FB_W   = 32;
    localparam int FB_H   = 6;
    localparam int DEPTH  = 4;
    localparam int NPIX   = FB_W * FB_H;
    localparam int NBYTES = NPIX / 8;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, out_b, rdy_b, byte_ready;
    logic [8:0] x_b;
    logic [7:0] y_b;
    logic       read_b, byte_valid, busy, done;
    logic [7:0] byte_data;
    logic [2:0] level;
`ifdef FB_READER_CRC_EN
    logic [7:0] crc;
`endif

    always #5 clk = ~clk;

    fb_reader #(.FB_W(FB_W), .FB_H(FB_H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_b(x_b), .y_b(y_b), .read_b(read_b), .out_b(out_b), .rdy_b(rdy_b),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done), .level(level)
`ifdef FB_READER_CRC_EN
        , .crc(crc)
`endif
    );

    int checks = 0;
    int errors = 0;
    int pmode = 0;
    int rmode = 1;
    int lat_min = 1;
    int lat_max = 1;
    logic img [FB_H][FB_W];

    int cd = 0;
    int reads = 0, seq_err = 0, proto_err = 0, unstable = 0, seq_next = 0;
    bit stale = 1'b0;
    logic [8:0] rq_x, first_x, last_x;
    logic [7:0] rq_y, first_y, last_y;

    logic [7:0] got_q [$];
    int done_cnt = 0, done_at = 0, busy_at_done = 0, hold_err = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data;

    // Framebuffer contents as a function of pixel coordinates.
    function automatic logic pix(input int x, input int y);
        case (pmode)
            0:       return 1'b0;
            1:       return ~x[0];
            2:       return 1'b1;
            default: return img[y][x];
        endcase
    endfunction

    // Byte i of the frame: pixels 8i..8i+7 in raster order, first in bit 7.
    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] e;
        for (int b = 0; b < 8; b++) e[7-b] = pix((8*i + b) % FB_W, (8*i + b) / FB_W);
        return e;
    endfunction

    function automatic int stream_bad(input int base, output int fi);
        int n = 0;
        fi = -1;
        for (int i = 0; i < NBYTES; i++) begin
            if (base + i >= got_q.size() || got_q[base+i] !== exp_byte(i)) begin
                n++;
                if (fi < 0) fi = i;
            end
        end
        return n;
    endfunction

    task automatic fill_img();
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++) img[y][x] = 1'($urandom_range(1, 0));
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit to);
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #2;
            if (done_cnt > d0) begin to = 1'b0; break; end
        end
    endtask

    // RAM port B model: one outstanding read, answered after a random latency.
    initial begin
        rdy_b = 1'b0;
        out_b = 1'b0;
        forever begin
            @(negedge clk); #1;
            rdy_b = 1'b0;
            if (!rst_n) begin
                cd = 0;
                stale = 1'b0;
            end else begin
                if (!busy) seq_next = 0;
                if (cd > 0) begin
                    if (!stale && (x_b !== rq_x || y_b !== rq_y)) unstable++;
                    cd--;
                    if (cd == 0) begin
                        rdy_b = 1'b1;
                        out_b = pix(int'(rq_x), int'(rq_y));
                        stale = 1'b0;
                    end
                end
                if (abort && cd > 0) stale = 1'b1;
                if (read_b) begin
                    if (cd != 0) proto_err++;
                    if (int'(y_b) * FB_W + int'(x_b) != seq_next) seq_err++;
                    if (seq_next == 0) begin first_x = x_b; first_y = y_b; end
                    last_x = x_b;
                    last_y = y_b;
                    seq_next++;
                    reads++;
                    rq_x = x_b;
                    rq_y = y_b;
                    cd = int'($urandom_range(lat_max, lat_min));
                end
            end
        end
    end

    // Byte consumer and done observer.
    initial begin
        byte_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       byte_ready = 1'b0;
                1:       byte_ready = 1'b1;
                default: byte_ready = 1'($urandom_range(1, 0));
            endcase
            #1;
            if (prev_stall && byte_valid && byte_data !== prev_data) hold_err++;
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
            if (rst_n && byte_valid && byte_ready) got_q.push_back(byte_data);
            if (done) begin
                done_cnt++;
                done_at = got_q.size();
                if (busy) busy_at_done++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++; if ({x_b, y_b} !== 17'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x_b, y_b); end
        checks++; if (read_b !== 1'b0) begin errors++; $display("FAIL reset_read_b: got %b want 0", read_b); end
        checks++; if (byte_valid !== 1'b0 || byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte: got v=%b d=%h want 0 00", byte_valid, byte_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_zero_frame();
        int r0, g0, d0, b0, s0, p0, fi, bad;
        bit to;
        pmode = 0; rmode = 1; lat_min = 1; lat_max = 1;
        r0 = reads; g0 = got_q.size(); d0 = done_cnt; b0 = busy_at_done; s0 = seq_err; p0 = proto_err;
        pulse_start();
        wait_done(d0, 5000, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: got no done want done"); end
        checks++; if (got_q.size() - g0 != NBYTES) begin errors++; $display("FAIL zero_count: got %0d want %0d", got_q.size() - g0, NBYTES); end
        bad = stream_bad(g0, fi);
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_data: got %0d bad bytes (first %0d) want 0", bad, fi); end
        checks++; if (reads - r0 != NPIX) begin errors++; $display("FAIL zero_reads: got %0d want %0d", reads - r0, NPIX); end
        checks++; if (done_at - g0 != NBYTES) begin errors++; $display("FAIL zero_done_pos: got %0d want %0d", done_at - g0, NBYTES); end
        checks++; if (busy_at_done != b0) begin errors++; $display("FAIL zero_busy_at_done: got %0d want %0d", busy_at_done, b0); end
        checks++; if (seq_err != s0 || proto_err != p0) begin errors++; $display("FAIL zero_ram_order: got seq %0d proto %0d want %0d %0d", seq_err, proto_err, s0, p0); end
        repeat (4) @(negedge clk);
        #2;
        checks++; if (busy !== 1'b0 || done_cnt != d0 + 1) begin errors++; $display("FAIL zero_idle: got busy=%b dones=%0d want 0 %0d", busy, done_cnt - d0, 1); end
    endtask

    task automatic test_alt_pattern();
        int g0, d0, naa;
        bit to;
        pmode = 1; rmode = 1; lat_min = 1; lat_max = 1;
        g0 = got_q.size(); d0 = done_cnt;
        pulse_start();
        wait_done(d0, 5000, to);
        naa = 0;
        for (int i = g0; i < got_q.size(); i++) if (got_q[i] === 8'hAA) naa++;
        checks++; if (to || naa != NBYTES) begin errors++; $display("FAIL alt_bytes: got %0d bytes of AA want %0d", naa, NBYTES); end
        checks++; if (first_x !== 9'd0 || first_y !== 8'd0) begin errors++; $display("FAIL alt_first: got %0d,%0d want 0,0", first_x, first_y); end
        checks++; if (int'(last_x) != FB_W - 1 || int'(last_y) != FB_H - 1) begin errors++; $display("FAIL alt_last: got %0d,%0d want %0d,%0d", last_x, last_y, FB_W - 1, FB_H - 1); end
    endtask

    task automatic test_backpressure();
        int r0, r1, g0, d0, h0, fi, bad;
        bit to;
        fill_img();
        pmode = 3; rmode = 0; lat_min = 1; lat_max = 1;
        r0 = reads; g0 = got_q.size(); d0 = done_cnt; h0 = hold_err;
        pulse_start();
        repeat (150) @(negedge clk);
        #2;
        checks++; if (level !== 3'(DEPTH) || byte_valid !== 1'b1) begin errors++; $display("FAIL bp_level: got %0d v=%b want %0d v=1", level, byte_valid, DEPTH); end
        r1 = reads;
        repeat (30) @(negedge clk);
        #2;
        checks++; if (reads != r1 || reads - r0 != (DEPTH + 1) * 8) begin errors++; $display("FAIL bp_stall_reads: got %0d want %0d", reads - r0, (DEPTH + 1) * 8); end
        rmode = 1;
        wait_done(d0, 5000, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
        bad = stream_bad(g0, fi);
        checks++; if (bad != 0 || got_q.size() - g0 != NBYTES) begin errors++; $display("FAIL bp_data: got %0d bad (first %0d) of %0d bytes want 0 of %0d", bad, fi, got_q.size() - g0, NBYTES); end
        checks++; if (hold_err != h0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", hold_err - h0); end
    endtask

    task automatic test_random_latency();
        int r0, g0, d0, u0, s0, p0, fi, bad;
        bit to;
        fill_img();
        pmode = 3; rmode = 2; lat_min = 1; lat_max = 5;
        r0 = reads; g0 = got_q.size(); d0 = done_cnt; u0 = unstable; s0 = seq_err; p0 = proto_err;
        pulse_start();
        wait_done(d0, 10000, to);
        checks++; if (to) begin errors++; $display("FAIL rl_timeout: got no done want done"); end
        bad = stream_bad(g0, fi);
        checks++; if (bad != 0 || got_q.size() - g0 != NBYTES) begin errors++; $display("FAIL rl_data: got %0d bad (first %0d) of %0d bytes want 0 of %0d", bad, fi, got_q.size() - g0, NBYTES); end
        checks++; if (unstable != u0) begin errors++; $display("FAIL rl_addr_stable: got %0d moves want 0", unstable - u0); end
        checks++; if (seq_err != s0 || proto_err != p0 || reads - r0 != NPIX) begin errors++; $display("FAIL rl_ram_order: got seq %0d proto %0d reads %0d want 0 0 %0d", seq_err - s0, proto_err - p0, reads - r0, NPIX); end
    endtask

    task automatic test_start_ignored();
        int r0, g0, d0, fi, bad;
        bit to;
        fill_img();
        pmode = 3; rmode = 1; lat_min = 1; lat_max = 2;
        r0 = reads; g0 = got_q.size(); d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        wait_done(d0, 10000, to);
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        checks++; if (to) begin errors++; $display("FAIL si_timeout: got no done want done"); end
        checks++; if (busy !== 1'b0 || reads - r0 != NPIX) begin errors++; $display("FAIL si_no_restart: got busy=%b reads %0d want 0 %0d", busy, reads - r0, NPIX); end
        bad = stream_bad(g0, fi);
        checks++; if (bad != 0 || done_cnt != d0 + 1) begin errors++; $display("FAIL si_data: got %0d bad (first %0d) dones %0d want 0 1", bad, fi, done_cnt - d0); end
    endtask

    task automatic test_abort();
        int r0, g0, d0, p0, fi, bad;
        bit to;
        fill_img();
        pmode = 3; rmode = 2; lat_min = 3; lat_max = 3;
        g0 = got_q.size(); d0 = done_cnt;
        pulse_start();
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (got_q.size() - g0 >= 10 && byte_valid) begin to = 1'b0; break; end
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        #2;
        checks++; if (to) begin errors++; $display("FAIL ab_reach: got %0d bytes want 10 with FIFO non-empty", got_q.size() - g0); end
        checks++; if (busy !== 1'b0 || byte_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL ab_flush: got busy=%b v=%b level=%0d want 0 0 0", busy, byte_valid, level); end
        checks++; if ({x_b, y_b} !== 17'd0 || done_cnt != d0) begin errors++; $display("FAIL ab_state: got %0d,%0d dones %0d want 0,0 0", x_b, y_b, done_cnt - d0); end
        lat_min = 1; lat_max = 5; rmode = 1;
        r0 = reads; g0 = got_q.size(); d0 = done_cnt; p0 = proto_err;
        pulse_start();
        wait_done(d0, 10000, to);
        checks++; if (to) begin errors++; $display("FAIL ab_restart_timeout: got no done want done"); end
        checks++; if (first_x !== 9'd0 || first_y !== 8'd0 || reads - r0 != NPIX) begin errors++; $display("FAIL ab_restart_addr: got %0d,%0d reads %0d want 0,0 %0d", first_x, first_y, reads - r0, NPIX); end
        checks++; if (proto_err != p0) begin errors++; $display("FAIL ab_reissue: got %0d early read_b want 0", proto_err - p0); end
        bad = stream_bad(g0, fi);
        checks++; if (bad != 0 || got_q.size() - g0 != NBYTES) begin errors++; $display("FAIL ab_restart_data: got %0d bad (first %0d) of %0d bytes want 0 of %0d", bad, fi, got_q.size() - g0, NBYTES); end
    endtask

    task automatic test_reset_midframe();
        int g0, d0, s0, fi, bad;
        bit to;
        fill_img();
        pmode = 3; rmode = 2; lat_min = 1; lat_max = 3;
        g0 = got_q.size(); d0 = done_cnt;
        pulse_start();
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (got_q.size() - g0 >= 5) begin to = 1'b0; break; end
        end
        rst_n = 1'b0;
        #2;
        checks++; if (to || {x_b, y_b, read_b, byte_valid, byte_data, busy, done, level} !== 32'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", {x_b, y_b, read_b, byte_valid, byte_data, busy, done, level}); end
        @(negedge clk); rst_n = 1'b1;
        rmode = 1;
        g0 = got_q.size(); d0 = done_cnt; s0 = seq_err;
        pulse_start();
        wait_done(d0, 10000, to);
        bad = stream_bad(g0, fi);
        checks++; if (to || bad != 0 || got_q.size() - g0 != NBYTES) begin errors++; $display("FAIL rst_mid_next_frame: got %0d bad (first %0d) of %0d bytes want 0 of %0d", bad, fi, got_q.size() - g0, NBYTES); end
        checks++; if (seq_err != s0) begin errors++; $display("FAIL rst_mid_order: got %0d out-of-order reads want 0", seq_err - s0); end
    endtask

`ifdef FB_READER_CRC_EN
    function automatic logic [7:0] crc_model();
        logic [7:0] c, d;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            d = exp_byte(i);
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ d[b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic test_crc();
        int d0;
        bit to;
        logic [7:0] want;
        pmode = 2; rmode = 1; lat_min = 1; lat_max = 1;
        want = crc_model();
        d0 = done_cnt;
        pulse_start();
        #2;
        checks++; if (crc !== 8'h00) begin errors++; $display("FAIL crc_clear: got %h want 00", crc); end
        wait_done(d0, 5000, to);
        checks++; if (to || crc !== want) begin errors++; $display("FAIL crc_value: got %h want %h", crc, want); end
        repeat (5) @(negedge clk);
        #2;
        checks++; if (crc !== want) begin errors++; $display("FAIL crc_hold: got %h want %h", crc, want); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        test_reset();
        test_zero_frame();
        test_alt_pattern();
        test_backpressure();
        test_random_latency();
        test_start_ignored();
        test_abort();
        test_reset_midframe();
`ifdef FB_READER_CRC_EN
        test_crc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
